// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM master port between two clients, with in-order read-tag routing.
// Define ARB_FIXED_PRIORITY_EN to make client 1 always win contention and keep the grant while it requests.
module sdram_port_arbiter #(
  parameter int ADDR_W      = 25,
  parameter int W           = 16,
  parameter int MAX_PENDING = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             c0_read,
  input  logic                             c0_write,
  input  logic [ADDR_W-1:0]                c0_address,
  input  logic [W-1:0]                     c0_writedata,
  output logic                             c0_waitrequest,
  output logic [W-1:0]                     c0_readdata,
  output logic                             c0_readdatavalid,
  input  logic                             c1_read,
  input  logic                             c1_write,
  input  logic [ADDR_W-1:0]                c1_address,
  input  logic [W-1:0]                     c1_writedata,
  output logic                             c1_waitrequest,
  output logic [W-1:0]                     c1_readdata,
  output logic                             c1_readdatavalid,
  output logic                             m_read,
  output logic                             m_write,
  output logic [ADDR_W-1:0]                m_address,
  output logic [W-1:0]                     m_writedata,
  input  logic                             m_waitrequest,
  input  logic [W-1:0]                     m_readdata,
  input  logic                             m_readdatavalid,
  output logic [$clog2(MAX_PENDING):0]     pending,
  output logic                             err_orphan
);

  localparam int PW = $clog2(MAX_PENDING);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {NONE, G0, G1} state_t;

  state_t           state, state_nxt;
  logic             last;
  logic [PW-1:0]    wptr, rptr;
  logic [MAX_PENDING-1:0] tag_mem;

  logic             req0, req1;
  logic             sel_rd, sel_wr, rd_cmd, rd_block;
  logic [ADDR_W-1:0] sel_addr;
  logic [W-1:0]     sel_data;
  logic             full, pop, push, accept, tag_head;

  assign req0 = c0_read | c0_write;
  assign req1 = c1_read | c1_write;

  always_comb begin
    sel_rd   = 1'b0;
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    case (state)
      G0: begin
        sel_rd   = c0_read;
        sel_wr   = c0_write;
        sel_addr = c0_address;
        sel_data = c0_writedata;
      end
      G1: begin
        sel_rd   = c1_read;
        sel_wr   = c1_write;
        sel_addr = c1_address;
        sel_data = c1_writedata;
      end
      default: ;
    endcase
  end

  // A response popping this cycle frees the slot, so a full FIFO need not block the read.
  assign full     = (pending == CW'(MAX_PENDING));
  assign pop      = m_readdatavalid && (pending != '0);
  assign rd_cmd   = sel_rd & ~sel_wr;
  assign rd_block = rd_cmd & full & ~pop;

  assign m_read      = rd_cmd & ~rd_block;
  assign m_write     = sel_wr;
  assign m_address   = sel_addr;
  assign m_writedata = sel_data;

  assign accept = (m_read | m_write) & ~m_waitrequest;
  assign push   = m_read & ~m_waitrequest;

  assign c0_waitrequest = ~((state == G0) & accept);
  assign c1_waitrequest = ~((state == G1) & accept);

  assign tag_head         = tag_mem[rptr];
  assign c0_readdatavalid = pop & ~tag_head;
  assign c1_readdatavalid = pop & tag_head;
  assign c0_readdata      = m_readdata;
  assign c1_readdata      = m_readdata;

  always_comb begin
    state_nxt = state;
    case (state)
      NONE: begin
        if (req0 && req1) begin
`ifdef ARB_FIXED_PRIORITY_EN
          state_nxt = G1;
`else
          state_nxt = last ? G0 : G1;
`endif
        end else if (req0) begin
          state_nxt = G0;
        end else if (req1) begin
          state_nxt = G1;
        end
      end
      G0: begin
        if (accept) begin
          if (req1)      state_nxt = G1;
          else if (req0) state_nxt = G0;
          else           state_nxt = NONE;
        end else if (!req0) begin
          state_nxt = NONE;
        end
      end
      G1: begin
        if (accept) begin
`ifdef ARB_FIXED_PRIORITY_EN
          if (req1)      state_nxt = G1;
          else if (req0) state_nxt = G0;
          else           state_nxt = NONE;
`else
          if (req0)      state_nxt = G0;
          else if (req1) state_nxt = G1;
          else           state_nxt = NONE;
`endif
        end else if (!req1) begin
          state_nxt = NONE;
        end
      end
      default: state_nxt = NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= NONE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last       <= 1'b1;
      wptr       <= '0;
      rptr       <= '0;
      pending    <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (accept) last <= (state == G1);
      if (push)   wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: ;
      endcase
      if (m_readdatavalid && (pending == '0)) err_orphan <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read behind a valid push.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wptr] <= (state == G1);
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: command ordering, read routing, FIFO-full stall, orphan/reset.
module tb_sdram_port_arbiter;
  localparam int ADDR_W = 25;
  localparam int W      = 16;
  localparam int MP     = 4;
  localparam int CW     = $clog2(MP) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              c0_read, c0_write, c1_read, c1_write;
  logic [ADDR_W-1:0] c0_address, c1_address;
  logic [W-1:0]      c0_writedata, c1_writedata;
  logic              c0_waitrequest, c1_waitrequest;
  logic [W-1:0]      c0_readdata, c1_readdata;
  logic              c0_readdatavalid, c1_readdatavalid;
  logic              m_read, m_write;
  logic [ADDR_W-1:0] m_address;
  logic [W-1:0]      m_writedata;
  logic              m_waitrequest;
  logic [W-1:0]      m_readdata;
  logic              m_readdatavalid;
  logic [CW-1:0]     pending;
  logic              err_orphan;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .W(W), .MAX_PENDING(MP)) dut (
    .clk(clk), .rst(rst),
    .c0_read(c0_read), .c0_write(c0_write), .c0_address(c0_address),
    .c0_writedata(c0_writedata), .c0_waitrequest(c0_waitrequest),
    .c0_readdata(c0_readdata), .c0_readdatavalid(c0_readdatavalid),
    .c1_read(c1_read), .c1_write(c1_write), .c1_address(c1_address),
    .c1_writedata(c1_writedata), .c1_waitrequest(c1_waitrequest),
    .c1_readdata(c1_readdata), .c1_readdatavalid(c1_readdatavalid),
    .m_read(m_read), .m_write(m_write), .m_address(m_address),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .pending(pending), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         client;
    logic [W-1:0] data;
  } rsp_t;

  rsp_t              rsp_q[$];
  logic [ADDR_W:0]   obs_q[$];
  rsp_t              rsp_e;
  int                errors = 0;
  int                checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accepted master commands and routed read responses.
  always @(negedge clk) begin
    if (!rst && (m_read || m_write) && !m_waitrequest)
      obs_q.push_back({m_write, m_address});
    if (c0_readdatavalid || c1_readdatavalid) begin
      check("rdv_one_hot", 32'(c0_readdatavalid & c1_readdatavalid), 32'd0);
      check("rdv_expected", 32'(rsp_q.size() != 0), 32'd1);
      if (rsp_q.size() != 0) begin
        rsp_e = rsp_q.pop_front();
        check("rdv_client", 32'(c1_readdatavalid), 32'(rsp_e.client));
        check("rdv_data", 32'(c1_readdatavalid ? c1_readdata : c0_readdata), 32'(rsp_e.data));
      end
    end
  end

  task automatic do_cmd(input bit cl, input bit rd, input logic [ADDR_W-1:0] a,
                        input logic [W-1:0] d);
    int n = 0;
    bit done = 1'b0;
    if (cl) begin
      c1_read = rd; c1_write = !rd; c1_address = a; c1_writedata = d;
    end else begin
      c0_read = rd; c0_write = !rd; c0_address = a; c0_writedata = d;
    end
    while (!done && n < 50) begin
      @(negedge clk);
      if (!(cl ? c1_waitrequest : c0_waitrequest)) done = 1'b1;
      n++;
    end
    check("cmd_accept_in_budget", 32'(done), 32'd1);
    @(posedge clk); #1;
    if (cl) begin c1_read = 1'b0; c1_write = 1'b0; end
    else    begin c0_read = 1'b0; c0_write = 1'b0; end
  endtask

  task automatic respond(input bit cl, input logic [W-1:0] d);
    rsp_q.push_back({cl, d});
    @(posedge clk); #1;
    m_readdatavalid = 1'b1;
    m_readdata      = d;
    @(posedge clk); #1;
    m_readdatavalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [ADDR_W-1:0] exp_addr [8];
    rst = 1'b1;
    c0_read = 0; c0_write = 0; c0_address = '0; c0_writedata = '0;
    c1_read = 0; c1_write = 0; c1_address = '0; c1_writedata = '0;
    m_waitrequest = 0; m_readdata = '0; m_readdatavalid = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_c0_wait", 32'(c0_waitrequest), 32'd1);
    check("rst_c1_wait", 32'(c1_waitrequest), 32'd1);
    check("rst_m_read", 32'(m_read), 32'd0);
    check("rst_m_write", 32'(m_write), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_err_orphan", 32'(err_orphan), 32'd0);

    // Single write: one-cycle arbitration latency, one master write cycle
    @(posedge clk); #1;
    c0_write = 1'b1; c0_address = 25'h10; c0_writedata = 16'h0003;
    @(negedge clk);
    check("w_arb_wait", 32'(c0_waitrequest), 32'd1);
    check("w_arb_no_write", 32'(m_write), 32'd0);
    @(negedge clk);
    check("w_m_write", 32'(m_write), 32'd1);
    check("w_m_address", 32'(m_address), 32'h10);
    check("w_m_writedata", 32'(m_writedata), 32'h3);
    check("w_c0_accept", 32'(c0_waitrequest), 32'd0);
    @(posedge clk); #1 c0_write = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("w_single_cycle", 32'(m_write), 32'd0);
    end

    // Contending continuous writes
    repeat (3) @(posedge clk);
    obs_q.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) do_cmd(1'b0, 1'b0, ADDR_W'(32'h100 + i), W'(i));
      end
      begin
        for (int i = 0; i < 4; i++) do_cmd(1'b1, 1'b0, ADDR_W'(32'h200 + i), W'(i));
      end
    join
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
`ifdef ARB_FIXED_PRIORITY_EN
      exp_addr[k] = (k < 4) ? ADDR_W'(32'h200 + k) : ADDR_W'(32'h100 + k - 4);
`else
      exp_addr[k] = (k % 2 == 0) ? ADDR_W'(32'h200 + k / 2) : ADDR_W'(32'h100 + k / 2);
`endif
    end
    check("arb_cmd_count", 32'(obs_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < obs_q.size(); k++)
      check("arb_order", 32'(obs_q[k]), 32'({1'b1, exp_addr[k]}));

    // Two reads from different clients, responses routed in order
    repeat (2) @(posedge clk);
    do_cmd(1'b0, 1'b1, 25'h4, '0);
    @(negedge clk); check("rd_pending_1", 32'(pending), 32'd1);
    do_cmd(1'b1, 1'b1, 25'h8, '0);
    @(negedge clk); check("rd_pending_2", 32'(pending), 32'd2);
    repeat (3) @(posedge clk);
    respond(1'b0, 16'hAAAA);
    @(negedge clk); check("rd_pending_back_1", 32'(pending), 32'd1);
    respond(1'b1, 16'h5555);
    @(negedge clk); check("rd_pending_back_0", 32'(pending), 32'd0);

    // FIFO full: fifth read stalls until a response frees a slot in the same cycle
    repeat (2) @(posedge clk);
    for (int i = 0; i < 4; i++) do_cmd(1'b1, 1'b1, ADDR_W'(32'h300 + i), '0);
    c1_read = 1'b1; c1_address = 25'h304;
    repeat (3) begin
      @(negedge clk);
      check("full_c1_wait", 32'(c1_waitrequest), 32'd1);
      check("full_m_read_off", 32'(m_read), 32'd0);
    end
    check("full_pending", 32'(pending), 32'd4);
    rsp_q.push_back({1'b1, 16'h1111});
    @(posedge clk); #1;
    m_readdatavalid = 1'b1; m_readdata = 16'h1111;
    @(negedge clk);
    check("full_release_wait", 32'(c1_waitrequest), 32'd0);
    check("full_release_read", 32'(m_read), 32'd1);
    check("full_release_addr", 32'(m_address), 32'h304);
    @(posedge clk); #1;
    m_readdatavalid = 1'b0; c1_read = 1'b0;
    @(negedge clk); check("full_push_pop_pending", 32'(pending), 32'd4);
    for (int i = 0; i < 4; i++) respond(1'b1, W'(32'h2000 + i));
    @(negedge clk); check("full_drained", 32'(pending), 32'd0);

    // Orphan response with nothing pending
    @(posedge clk); #1;
    m_readdatavalid = 1'b1; m_readdata = 16'hDEAD;
    @(negedge clk);
    check("orphan_no_c0", 32'(c0_readdatavalid), 32'd0);
    check("orphan_no_c1", 32'(c1_readdatavalid), 32'd0);
    @(posedge clk); #1 m_readdatavalid = 1'b0;
    @(negedge clk);
    check("orphan_flag", 32'(err_orphan), 32'd1);
    check("orphan_pending", 32'(pending), 32'd0);

    // Reset with two reads outstanding, then a late response
    do_cmd(1'b0, 1'b1, 25'h40, '0);
    do_cmd(1'b0, 1'b1, 25'h41, '0);
    @(negedge clk); check("abort_pending_2", 32'(pending), 32'd2);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_pending_0", 32'(pending), 32'd0);
    check("abort_orphan_clr", 32'(err_orphan), 32'd0);
    check("abort_c0_wait", 32'(c0_waitrequest), 32'd1);
    @(posedge clk); #1;
    m_readdatavalid = 1'b1; m_readdata = 16'hAAAA;
    @(posedge clk); #1 m_readdatavalid = 1'b0;
    @(negedge clk);
    check("late_rsp_orphan", 32'(err_orphan), 32'd1);
    check("late_rsp_pending", 32'(pending), 32'd0);

    check("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
